// File: rtl/pc_fetch.sv
// pc_fetch: instruction-fetch stage with PC register and IF/ID pipeline register.
//
// Ports
//   clk          single clock, all state updates on the rising edge
//   rst_n        synchronous active-low reset
//   stall        hold PC and IF/ID register
//   flush        squash IF/ID contents (loads a NOP bubble)
//   pcsrc        next-PC select: 00 seq, 01 branch/jal, 10 jalr, 11 treated as 00
//   imm_ext      sign-extended immediate from decode/execute
//   branch_pc    PC of the redirecting instruction
//   rs1_data     register operand for jalr
//   instr_in     instruction returned combinationally by memory for addr
//   addr         current fetch PC (straight from the PC register)
//   instr_d      IF/ID instruction
//   pc_d         IF/ID PC of instr_d
//   pcplus4_d    IF/ID pc_d + 4
//   valid_d      instr_d is a real fetched instruction
//   misalign_err one-cycle pulse after a redirect whose target had bits[1:0] != 0
module pc_fetch #(
  parameter int                     ADDRESS_WIDTH = 32,
  parameter int                     DATA_WIDTH    = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC    = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     stall,
  input  logic                     flush,
  input  logic [1:0]               pcsrc,
  input  logic [ADDRESS_WIDTH-1:0] imm_ext,
  input  logic [ADDRESS_WIDTH-1:0] branch_pc,
  input  logic [ADDRESS_WIDTH-1:0] rs1_data,
  input  logic [DATA_WIDTH-1:0]    instr_in,
  output logic [ADDRESS_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0]    instr_d,
  output logic [ADDRESS_WIDTH-1:0] pc_d,
  output logic [ADDRESS_WIDTH-1:0] pcplus4_d,
  output logic                     valid_d,
  output logic                     misalign_err
);

  localparam logic [DATA_WIDTH-1:0]    NOP_INSTR = DATA_WIDTH'(32'h0000_0013);
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_ZERO = '0;
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_FOUR = ADDRESS_WIDTH'(4);

  // jalr target: bit0 is architecturally dropped before alignment is judged.
  function automatic logic [ADDRESS_WIDTH-1:0] clear_bit0(input logic [ADDRESS_WIDTH-1:0] a);
    return {a[ADDRESS_WIDTH-1:1], 1'b0};
  endfunction

  // Fetch addresses are always word aligned; misaligned targets are forced down.
  function automatic logic [ADDRESS_WIDTH-1:0] word_align(input logic [ADDRESS_WIDTH-1:0] a);
    return {a[ADDRESS_WIDTH-1:2], 2'b00};
  endfunction

  logic        [ADDRESS_WIDTH-1:0] pc_p0;
  logic signed [ADDRESS_WIDTH-1:0] imm_s;
  logic        [ADDRESS_WIDTH-1:0] pcplus4;
  logic        [ADDRESS_WIDTH-1:0] target_raw;
  logic                            redirect;
  logic                            target_misaligned;

  assign imm_s   = imm_ext;
  assign pcplus4 = pc_p0 + ADDR_FOUR;
  assign addr    = pc_p0;

  assign redirect = (pcsrc == 2'b01) || (pcsrc == 2'b10);

  always_comb begin
    target_raw = pcplus4;
    case (pcsrc)
      2'b01:   target_raw = branch_pc + $unsigned(imm_s);
      2'b10:   target_raw = clear_bit0(rs1_data + $unsigned(imm_s));
      default: target_raw = pcplus4;
    endcase
  end

  assign target_misaligned = (target_raw[1:0] != 2'b00);

  // Stage boundary: PC register (p0) -> IF/ID register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_p0        <= RESET_PC;
      instr_d      <= NOP_INSTR;
      pc_d         <= ADDR_ZERO;
      pcplus4_d    <= ADDR_ZERO;
      valid_d      <= 1'b0;
      misalign_err <= 1'b0;
    end else if (redirect) begin
      pc_p0        <= word_align(target_raw);
      instr_d      <= NOP_INSTR;
      pc_d         <= ADDR_ZERO;
      pcplus4_d    <= ADDR_ZERO;
      valid_d      <= 1'b0;
      misalign_err <= target_misaligned;
    end else if (flush) begin
      // The squashed slot is dropped, but PC still advances unless stalled.
      pc_p0        <= stall ? pc_p0 : pcplus4;
      instr_d      <= NOP_INSTR;
      pc_d         <= ADDR_ZERO;
      pcplus4_d    <= ADDR_ZERO;
      valid_d      <= 1'b0;
      misalign_err <= 1'b0;
    end else if (stall) begin
      misalign_err <= 1'b0;
    end else begin
      pc_p0        <= pcplus4;
      instr_d      <= instr_in;
      pc_d         <= pc_p0;
      pcplus4_d    <= pcplus4;
      valid_d      <= 1'b1;
      misalign_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pc_fetch.sv
// tb_pc_fetch: directed plus randomized checking of pc_fetch against an
// edge-by-edge behavioural reference model.
module tb_pc_fetch;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        flush;
  logic [1:0]  pcsrc;
  logic [31:0] imm_ext;
  logic [31:0] branch_pc;
  logic [31:0] rs1_data;
  logic [31:0] instr_in;
  logic [31:0] addr;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pcplus4_d;
  logic        valid_d;
  logic        misalign_err;

  int n_total = 0;
  int n_bad   = 0;

  // Reference state
  logic [31:0] m_pc, m_instr, m_pcd, m_pc4;
  logic        m_valid, m_mis;

  pc_fetch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .flush       (flush),
    .pcsrc       (pcsrc),
    .imm_ext     (imm_ext),
    .branch_pc   (branch_pc),
    .rs1_data    (rs1_data),
    .instr_in    (instr_in),
    .addr        (addr),
    .instr_d     (instr_d),
    .pc_d        (pc_d),
    .pcplus4_d   (pcplus4_d),
    .valid_d     (valid_d),
    .misalign_err(misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h00C0_FFEE;
  endfunction

  // Instruction memory: combinational read of the fetch address
  assign instr_in = mem_word(addr);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_nop();
    m_instr = 32'h0000_0013;
    m_pcd   = 32'h0;
    m_pc4   = 32'h0;
    m_valid = 1'b0;
  endtask

  // Predict the state after the coming rising edge from the current inputs.
  task automatic model_edge();
    logic [31:0] tgt;
    if (!rst_n) begin
      m_pc  = 32'h0;
      m_mis = 1'b0;
      model_nop();
    end else if (pcsrc == 2'd1 || pcsrc == 2'd2) begin
      if (pcsrc == 2'd1) tgt = branch_pc + imm_ext;
      else               tgt = (rs1_data + imm_ext) / 2 * 2;
      m_mis = (tgt % 4) != 0;
      m_pc  = tgt - (tgt % 4);
      model_nop();
    end else begin
      m_mis = 1'b0;
      if (flush) begin
        model_nop();
        if (!stall) m_pc = m_pc + 4;
      end else if (!stall) begin
        m_instr = mem_word(m_pc);
        m_pcd   = m_pc;
        m_pc4   = m_pc + 4;
        m_valid = 1'b1;
        m_pc    = m_pc + 4;
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".addr"},     addr,                 m_pc);
    check({tag, ".instr_d"},  instr_d,              m_instr);
    check({tag, ".pc_d"},     pc_d,                 m_pcd);
    check({tag, ".pcplus4"},  pcplus4_d,            m_pc4);
    check({tag, ".valid"},    {31'b0, valid_d},     {31'b0, m_valid});
    check({tag, ".misalign"}, {31'b0, misalign_err}, {31'b0, m_mis});
  endtask

  // One clock: predict, advance, sample 1 time unit after the edge.
  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic set_in(input logic [1:0] src, input logic [31:0] bpc,
                        input logic [31:0] imm, input logic [31:0] rs1,
                        input logic st, input logic fl);
    pcsrc     = src;
    branch_pc = bpc;
    imm_ext   = imm;
    rs1_data  = rs1;
    stall     = st;
    flush     = fl;
  endtask

  initial begin
    m_pc = 32'hDEAD_BEEF;
    model_nop();
    m_mis = 1'b0;
    rst_n = 1'b0;
    set_in(2'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);

    // Reset state
    step("rst0");
    step("rst1");
    check("rst.instr_nop", instr_d, 32'h0000_0013);

    // Reset release and sequential fetch
    rst_n = 1'b1;
    check("rel.addr", addr, 32'h0);
    step("seq1");
    check("seq1.addr_const", addr, 32'h4);
    check("seq1.instr_at0", instr_d, mem_word(32'h0));
    step("seq2");
    check("seq2.addr_const", addr, 32'h8);
    check("seq2.pcd_const", pc_d, 32'h4);

    // Branch at addr 8
    set_in(2'd1, 32'h4, 32'h10, 32'h0, 1'b0, 1'b0);
    step("br");
    check("br.addr_const", addr, 32'h14);
    check("br.valid_const", {31'b0, valid_d}, 32'h0);
    set_in(2'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    step("br_after");
    check("br_after.pcd_const", pc_d, 32'h14);

    // jalr with misaligned target
    set_in(2'd2, 32'h0, 32'h2, 32'h101, 1'b0, 1'b0);
    step("jalr");
    check("jalr.addr_const", addr, 32'h100);
    check("jalr.mis_const", {31'b0, misalign_err}, 32'h1);
    set_in(2'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    step("jalr_after");
    check("jalr_after.mis_const", {31'b0, misalign_err}, 32'h0);

    // Reach 0x20 with a real instruction in IF/ID, then stall
    set_in(2'd1, 32'h10, 32'hC, 32'h0, 1'b0, 1'b0);
    step("to1c");
    set_in(2'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    step("to20");
    stall = 1'b1;
    for (int i = 0; i < 3; i++) step("stall");
    check("stall.addr_const", addr, 32'h20);
    check("stall.pcd_const", pc_d, 32'h1C);
    set_in(2'd1, 32'h30, 32'h10, 32'h0, 1'b1, 1'b0);
    step("stall_br");
    check("stall_br.addr_const", addr, 32'h40);

    // Flush without and with stall
    set_in(2'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    step("pre_flush");
    flush = 1'b1;
    step("flush");
    stall = 1'b1;
    step("flush_stall");
    set_in(2'd3, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    step("pcsrc11");

    // Wraparound at the top of the address space
    set_in(2'd2, 32'h0, 32'hC, 32'hFFFF_FFF0, 1'b0, 1'b0);
    step("to_top");
    check("to_top.addr_const", addr, 32'hFFFF_FFFC);
    set_in(2'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    step("wrap");
    check("wrap.addr_const", addr, 32'h0);

    // Reset during a redirect
    rst_n = 1'b0;
    set_in(2'd1, 32'h100, 32'h7, 32'h0, 1'b1, 1'b1);
    step("rst_redir");
    check("rst_redir.addr_const", addr, 32'h0);
    rst_n = 1'b1;
    set_in(2'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    step("rst_redir_rel");

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] r;
      r = $urandom_range(0, 99);
      rst_n     = (r >= 2);
      r = $urandom_range(0, 9);
      pcsrc     = (r < 6) ? 2'd0 : (r < 8) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      stall     = ($urandom_range(0, 3) == 0);
      flush     = ($urandom_range(0, 5) == 0);
      branch_pc = $urandom;
      imm_ext   = $urandom;
      rs1_data  = $urandom;
      step("rand");
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
